// File: rtl/im_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package im_pkg;

  // Loader FSM states, in the order a normal load walks through them.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

  localparam int IM_WORDS   = 32;
  localparam int WORD_BYTES = 4;
  localparam int INSTR_W    = 32;
  localparam int PC_W       = 16;

endpackage

// File: rtl/im_word_assembler.sv
// Collects stream bytes LSB-first into one instruction word.
module im_word_assembler
  import im_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               accept,
  input  logic [7:0]         byte_data,
  output logic [1:0]         byte_cnt,
  output logic [INSTR_W-1:0] word_next,
  output logic               word_full
);

  logic [INSTR_W-1:0] word_q;

  // Current partial word with the incoming byte dropped into its lane.
  always_comb begin
    word_next = word_q;
    word_next[{byte_cnt, 3'b000} +: 8] = byte_data;
  end

  assign word_full = accept && (byte_cnt == 2'(WORD_BYTES - 1));

  // Byte lane counter wraps to zero after the last byte of each word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (accept) begin
      word_q   <= word_next;
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/im_boot_loader.sv
// Streams a length-prefixed program into instruction memory, holding the
// CPU in reset until the last word lands.
//
// Byte handshake: a byte moves on a rising edge where byte_valid and
// byte_ready are both high; byte_ready depends only on the FSM state, never
// on byte_valid, and byte_data is ignored whenever byte_valid is low.
module im_boot_loader
  import im_pkg::*;
#(
  parameter int ADDR_W      = PC_W,
  parameter int MAX_WORDS   = IM_WORDS,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               cpu_rst_n,
  output logic               done,
  output logic               err,
  output logic [5:0]         words_loaded,
  output logic [2:0]         dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t             state, state_nx;
  logic [15:0]        n_len;
  logic [15:0]        n_full;
  logic [5:0]         word_idx;
  logic [CNT_W-1:0]   idle_cnt;
  logic               accept;
  logic               start_ok;
  logic               counting;
  logic               timeout;
  logic               last_word;
  logic [1:0]         byte_cnt;
  logic [INSTR_W-1:0] word_next;
  logic               word_full;

  assign accept    = byte_valid && byte_ready;
  assign start_ok  = start && (state == IDLE || state == DONE || state == ERROR);
  assign counting  = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
  assign timeout   = counting && !accept && (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign n_full    = {byte_data, n_len[7:0]};
  assign last_word = (({10'd0, word_idx} + 16'd1) == n_len);
  assign dbg_state = state;

  im_word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_ok),
    .accept    (accept && (state == DATA)),
    .byte_data (byte_data),
    .byte_cnt  (byte_cnt),
    .word_next (word_next),
    .word_full (word_full)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state: length header, word bytes, one write cycle per word.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = LEN_LO;
      LEN_LO: begin
        if (accept)       state_nx = LEN_HI;
        else if (timeout) state_nx = ERROR;
      end
      LEN_HI: begin
        if (accept) begin
          if (n_full == 16'd0)                    state_nx = DONE;
          else if (n_full > 16'(MAX_WORDS))       state_nx = ERROR;
          else                                    state_nx = DATA;
        end else if (timeout) begin
          state_nx = ERROR;
        end
      end
      DATA: begin
        if (word_full)    state_nx = WRITE;
        else if (timeout) state_nx = ERROR;
      end
      WRITE:  state_nx = last_word ? DONE : DATA;
      DONE:   if (start) state_nx = LEN_LO;
      ERROR:  if (start) state_nx = LEN_LO;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded purely from the current state.
  always_comb begin
    byte_ready = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
    im_we      = (state == WRITE);
    done       = (state == DONE);
    err        = (state == ERROR);
    cpu_rst_n  = (state == DONE);
  end

  // Length latch, word index, write port registers and idle timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_len        <= '0;
      word_idx     <= '0;
      words_loaded <= '0;
      idle_cnt     <= '0;
      im_addr      <= '0;
      im_wdata     <= '0;
    end else if (start_ok) begin
      word_idx     <= '0;
      words_loaded <= '0;
      idle_cnt     <= '0;
    end else begin
      if (accept)        idle_cnt <= '0;
      else if (counting) idle_cnt <= idle_cnt + 1'b1;
      if (state == LEN_LO && accept) n_len[7:0]  <= byte_data;
      if (state == LEN_HI && accept) n_len[15:8] <= byte_data;
      // Address and data are captured with the 4th byte so the write
      // presents them the very next cycle and they hold afterwards.
      if (word_full) begin
        im_addr  <= ADDR_W'({word_idx, 2'b00});
        im_wdata <= word_next;
      end
      if (state == WRITE) begin
        word_idx     <= word_idx + 6'd1;
        words_loaded <= words_loaded + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_im_boot_loader.sv
// Directed + randomized bench for im_boot_loader against a stream-level model.
module tb_im_boot_loader;
  import im_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        im_we;
  logic [15:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_rst_n;
  logic        done;
  logic        err;
  logic [5:0]  words_loaded;
  logic [2:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]  stream[$];
  logic [31:0] exp_q[$];
  logic [15:0] exp_addr_q[$];
  logic        exp_done;
  logic        exp_err;
  int          exp_words;
  logic [15:0] last_addr;

  // Clock and reset.
  always #5 clk = ~clk;

  im_boot_loader #(.ADDR_W(16), .MAX_WORDS(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_rst_n(cpu_rst_n), .done(done), .err(err),
    .words_loaded(words_loaded), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: decode the whole stream into the writes it should cause.
  function automatic void build_model();
    int n;
    exp_q.delete();
    exp_addr_q.delete();
    n = int'(stream[0]) + 256 * int'(stream[1]);
    exp_done  = (n <= 32);
    exp_err   = (n > 32);
    exp_words = (n <= 32) ? n : 0;
    if (n <= 32) begin
      for (int w = 0; w < n; w++) begin
        exp_q.push_back({stream[2+4*w+3], stream[2+4*w+2], stream[2+4*w+1], stream[2+4*w]});
        exp_addr_q.push_back(16'(4 * w));
      end
    end
  endfunction

  task automatic make_random_stream(input int n);
    stream.delete();
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
    if (n <= 32)
      for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
  endtask

  task automatic make_fixed_stream();
    logic [7:0] fixed [14];
    fixed = '{8'h03, 8'h00, 8'h13, 8'h05, 8'hc0, 8'h00, 8'h93, 8'h05,
              8'h90, 8'h00, 8'h33, 8'h06, 8'hb5, 8'h40};
    stream.delete();
    for (int i = 0; i < 14; i++) stream.push_back(fixed[i]);
  endtask

  // Driver: one-cycle start pulse, returns on the negedge after the edge.
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Driver + scoreboard: feed the stream, check every write on the fly.
  // Called on a negedge; byte_ready depends only on state, so a byte driven
  // here with byte_ready high is taken on the coming posedge.
  task automatic run_load(input bit gaps, input int stop_after);
    int  idx = 0;
    int  cyc = 0;
    int  writes = 0;
    int  gap_run = 0;
    bit  fin = 1'b0;
    build_model();
    while (!fin && cyc < 4000) begin
      if (im_we) begin
        chk("ready_in_write", {31'd0, byte_ready}, 32'd0);
        chk("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          chk("wr_addr", {16'd0, im_addr}, {16'd0, exp_addr_q.pop_front()});
          chk("wr_data", im_wdata, exp_q.pop_front());
        end
        last_addr = im_addr;
        writes++;
      end
      if (stop_after > 0 && writes == stop_after) fin = 1'b1;
      else if (idx == stream.size() && (done || err)) fin = 1'b1;
      else begin
        byte_valid = (idx < stream.size()) &&
                     (!gaps || $urandom_range(0, 1) == 1 || gap_run >= 6);
        gap_run    = byte_valid ? 0 : gap_run + 1;
        byte_data  = byte_valid ? stream[idx] : 8'($urandom);
        if (byte_valid && byte_ready) idx++;
        @(negedge clk);
        cyc++;
      end
    end
    byte_valid = 1'b0;
    chk("load_finished", {31'd0, fin}, 32'd1);
  endtask

  task automatic chk_end(input string tag);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, exp_done});
    chk({tag, "_words"}, {26'd0, words_loaded}, 32'(exp_words));
    chk({tag, "_missing_writes"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_we", {31'd0, im_we}, 32'd0);
    chk("rst_addr", {16'd0, im_addr}, 32'd0);
    chk("rst_wdata", im_wdata, 32'd0);
    chk("rst_cpu", {31'd0, cpu_rst_n}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_words", {26'd0, words_loaded}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_state", {29'd0, dbg_state}, {29'd0, IDLE});

    // Normal load of the reference three-instruction program.
    pulse_start();
    make_fixed_stream();
    run_load(1'b0, 0);
    chk_end("normal");

    // Same stream with random valid gaps, started from DONE.
    pulse_start();
    chk("restart_cpu_low", {31'd0, cpu_rst_n}, 32'd0);
    chk("restart_done_low", {31'd0, done}, 32'd0);
    make_fixed_stream();
    run_load(1'b1, 0);
    chk_end("gaps");

    // N=0: done right after the header; later bytes refused.
    pulse_start();
    make_random_stream(0);
    run_load(1'b0, 0);
    chk_end("n0");
    byte_valid = 1'b1;
    byte_data  = 8'h5a;
    for (int i = 0; i < 3; i++) begin
      chk("n0_extra_refused", {31'd0, byte_ready}, 32'd0);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    chk("n0_still_done", {31'd0, done}, 32'd1);

    // N=32: full memory, last write at 124.
    pulse_start();
    make_random_stream(32);
    run_load(1'b1, 0);
    chk_end("n32");
    chk("n32_last_addr", {16'd0, last_addr}, 32'd124);

    // N=33: rejected after the header.
    pulse_start();
    make_random_stream(33);
    run_load(1'b0, 0);
    chk_end("n33");

    // Timeout: three bytes then silence.
    pulse_start();
    byte_valid = 1'b1;
    byte_data  = 8'h03; @(negedge clk);
    byte_data  = 8'h00; @(negedge clk);
    byte_data  = 8'h13; @(negedge clk);
    byte_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("to_not_yet", {31'd0, err}, 32'd0);
    @(negedge clk);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_ready", {31'd0, byte_ready}, 32'd0);
    chk("to_cpu", {31'd0, cpu_rst_n}, 32'd0);
    pulse_start();
    chk("to_err_cleared", {31'd0, err}, 32'd0);
    make_random_stream(5);
    run_load(1'b1, 0);
    chk_end("to_reload");

    // Reload from DONE with a single word.
    pulse_start();
    chk("reload_cpu_low", {31'd0, cpu_rst_n}, 32'd0);
    make_random_stream(1);
    run_load(1'b0, 0);
    chk_end("one_word");
    chk("one_word_addr", {16'd0, last_addr}, 32'd0);

    // Random loads of assorted sizes.
    for (int t = 0; t < 4; t++) begin
      pulse_start();
      make_random_stream($urandom_range(1, 10));
      run_load(1'b1, 0);
      chk_end("rand");
    end

    // Reset after two words of a three-word load.
    pulse_start();
    make_fixed_stream();
    run_load(1'b0, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("mid_rst_we", {31'd0, im_we}, 32'd0);
    chk("mid_rst_addr", {16'd0, im_addr}, 32'd0);
    chk("mid_rst_wdata", im_wdata, 32'd0);
    chk("mid_rst_cpu", {31'd0, cpu_rst_n}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    chk("mid_rst_words", {26'd0, words_loaded}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_state", {29'd0, dbg_state}, {29'd0, IDLE});
    chk("post_rst_ready", {31'd0, byte_ready}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
